// File: rtl/render_pkg.sv
// Shared types and defaults for the sprite renderer.
// Holds the FSM encoding and the address width.
package render_pkg;

  localparam int ADDR_W = 19;
  localparam int DEF_SCR_W = 640;
  localparam int DEF_SCR_H = 480;
  localparam logic [15:0] DEF_KEY = 16'hF81F;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

endpackage

// File: rtl/raster_ctr.sv
// Column/row raster counter for one tile.
// Column is the inner index; both wrap at their power-of-two size.
module raster_ctr #(
  parameter int W = 32,
  parameter int H = 32
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 en,
  output logic [$clog2(H)-1:0] row,
  output logic [$clog2(W)-1:0] col,
  output logic                 last
);

  localparam int CW = $clog2(W);
  localparam int RW = $clog2(H);

  logic col_end;

  assign col_end = (col == CW'(W - 1));
  assign last    = col_end && (row == RW'(H - 1));

  always_ff @(posedge clk) begin
    if (!rstn) begin
      row <= '0;
      col <= '0;
    end else if (en) begin
      if (col_end) begin
        col <= '0;
        row <= row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

endmodule

// File: rtl/render_sprite.sv
// Tile blitter: reads a tile from an external ROM and writes it
// into the framebuffer with flip, clipping and colour-key.
module render_sprite
  import render_pkg::*;
#(
  parameter int          TILE_W = 32,
  parameter int          TILE_H = 32,
  parameter int          SCR_W  = DEF_SCR_W,
  parameter int          SCR_H  = DEF_SCR_H,
  parameter logic [15:0] KEY    = DEF_KEY
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [ADDR_W-1:0] tile_id,
  input  logic [9:0]        top,
  input  logic [9:0]        left,
  input  logic              flip_h,
  input  logic              flip_v,
  input  logic              key_en,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] src_addr,
  input  logic [15:0]       src_data,
  output logic [ADDR_W-1:0] dst_addr,
  output logic [15:0]       dst_data,
  output logic              dst_wr
);

  localparam int LW = $clog2(TILE_W);
  localparam int LH = $clog2(TILE_H);
  localparam int TB = LW + LH;
  localparam logic [31:0] SW = SCR_W;
  localparam logic [31:0] SH = SCR_H;

  state_t state;
  logic [1:0] drain_cnt;

  logic [ADDR_W-1:0] tile_q;
  logic [9:0]        top_q;
  logic [9:0]        left_q;
  logic              fh_q;
  logic              fv_q;
  logic              key_q;

  logic [LH-1:0] row;
  logic [LW-1:0] col;
  logic          last;
  logic          idle_go;
  logic          issue;

  assign idle_go = (state == S_IDLE) && start;
  assign issue   = idle_go || (state == S_READ);

  raster_ctr #(
    .W(TILE_W),
    .H(TILE_H)
  ) u_ctr (
    .clk (clk),
    .rstn(rstn),
    .en  (issue),
    .row (row),
    .col (col),
    .last(last)
  );

  // Pixel 0 is issued on the accept edge, so it uses the live inputs.
  logic [ADDR_W-1:0] tid_c;
  logic [9:0]        top_c;
  logic [9:0]        left_c;
  logic              fh_c;
  logic              fv_c;

  assign tid_c  = idle_go ? tile_id : tile_q;
  assign top_c  = idle_go ? top     : top_q;
  assign left_c = idle_go ? left    : left_q;
  assign fh_c   = idle_go ? flip_h  : fh_q;
  assign fv_c   = idle_go ? flip_v  : fv_q;

  logic [LH-1:0]     sr;
  logic [LW-1:0]     sc;
  logic [ADDR_W-1:0] src_next;
  logic [10:0]       x_c;
  logic [10:0]       y_c;
  logic              in_c;
  logic [ADDR_W-1:0] lin_c;

  assign sr       = fv_c ? ~row : row;
  assign sc       = fh_c ? ~col : col;
  assign src_next = (tid_c << TB) + ADDR_W'({sr, sc});
  assign x_c      = {1'b0, left_c} + 11'(col);
  assign y_c      = {1'b0, top_c} + 11'(row);
  assign in_c     = (32'(x_c) < SW) && (32'(y_c) < SH);
  assign lin_c    = ADDR_W'(32'(y_c) * SW + 32'(x_c));

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= S_IDLE;
      drain_cnt <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      tile_q    <= '0;
      top_q     <= '0;
      left_q    <= '0;
      fh_q      <= 1'b0;
      fv_q      <= 1'b0;
      key_q     <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            state  <= S_READ;
            busy   <= 1'b1;
            tile_q <= tile_id;
            top_q  <= top;
            left_q <= left;
            fh_q   <= flip_h;
            fv_q   <= flip_v;
            key_q  <= key_en;
          end
        end
        S_READ: begin
          if (last) begin
            state     <= S_DRAIN;
            drain_cnt <= '0;
          end
        end
        S_DRAIN: begin
          drain_cnt <= drain_cnt + 2'd1;
          // Wait out the ROM and output-register slots of the last pixel.
          if (drain_cnt == 2'd2) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  logic              v1, v2;
  logic              in1, in2;
  logic [ADDR_W-1:0] a1, a2;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      src_addr <= '0;
      v1       <= 1'b0;
      v2       <= 1'b0;
      in1      <= 1'b0;
      in2      <= 1'b0;
      a1       <= '0;
      a2       <= '0;
      dst_wr   <= 1'b0;
      dst_addr <= '0;
      dst_data <= '0;
    end else begin
      v1 <= issue;
      if (issue) begin
        src_addr <= src_next;
        a1       <= lin_c;
        in1      <= in_c;
      end
      v2  <= v1;
      a2  <= a1;
      in2 <= in1;
      dst_wr <= v2 && in2 && !(key_q && (src_data == KEY));
      if (v2 && in2 && !(key_q && (src_data == KEY))) begin
        dst_addr <= a2;
        dst_data <= src_data;
      end
    end
  end

endmodule

// File: tb/tb_render_sprite.sv
// Randomised self-checking bench for render_sprite against a
// raster-loop reference model and a registered ROM model.
module tb_render_sprite;

  localparam int TW = 32;
  localparam int TH = 32;
  localparam int N  = TW * TH;
  localparam int SW = 640;
  localparam int SH = 480;
  localparam logic [15:0] KEYV = 16'hF81F;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic [18:0] tile_id;
  logic [9:0]  top;
  logic [9:0]  left;
  logic        flip_h;
  logic        flip_v;
  logic        key_en;
  logic        busy;
  logic        done;
  logic [18:0] src_addr;
  logic [15:0] src_data;
  logic [18:0] dst_addr;
  logic [15:0] dst_data;
  logic        dst_wr;

  int pass_n = 0;
  int total_n = 0;
  int rom_mode = 0;

  typedef struct {
    int          cyc;
    logic [18:0] a;
    logic [15:0] d;
  } wr_t;

  wr_t got_q[$];
  wr_t exp_q[$];
  logic [18:0] exp_src[N];
  logic [18:0] src_log[N];

  render_sprite dut (
    .clk     (clk),
    .rstn    (rstn),
    .start   (start),
    .tile_id (tile_id),
    .top     (top),
    .left    (left),
    .flip_h  (flip_h),
    .flip_v  (flip_v),
    .key_en  (key_en),
    .busy    (busy),
    .done    (done),
    .src_addr(src_addr),
    .src_data(src_data),
    .dst_addr(dst_addr),
    .dst_data(dst_data),
    .dst_wr  (dst_wr)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] rom_word(input logic [18:0] a);
    case (rom_mode)
      1: rom_word = a[0] ? a[15:0] : KEYV;
      2: rom_word = (a[3:0] == 4'h5) ? KEYV : (a[15:0] ^ 16'h5A5A);
      default: rom_word = a[15:0];
    endcase
  endfunction

  always @(posedge clk) src_data <= rom_word(src_addr);

  task automatic scramble();
    tile_id = 19'($urandom);
    top     = 10'($urandom);
    left    = 10'($urandom);
    flip_h  = 1'($urandom);
    flip_v  = 1'($urandom);
    key_en  = 1'($urandom);
  endtask

  task automatic run_render(
    input  logic [18:0] tid,
    input  logic [9:0]  t,
    input  logic [9:0]  l,
    input  logic        fh,
    input  logic        fv,
    input  logic        ke,
    input  int          md,
    input  bit          b2b,
    input  string       nm,
    output int          n_wr,
    output logic [18:0] s_first,
    output logic [18:0] s_last
  );
    int last_cyc;
    int done_n;
    int done_at;
    int bad;
    logic b1, bend, bdone;
    last_cyc = b2b ? N + 3 : N + 5;
    done_n = 0;
    done_at = -1;
    b1 = 1'b0;
    bend = 1'b0;
    bdone = 1'b1;
    rom_mode = md;
    exp_q.delete();
    got_q.delete();
    for (int r = 0; r < TH; r++) begin
      for (int c = 0; c < TW; c++) begin
        int sr, sc, x, y;
        logic [18:0] s;
        logic [15:0] dv;
        sr = fv ? TH - 1 - r : r;
        sc = fh ? TW - 1 - c : c;
        s = 19'(int'(tid) * N + sr * TW + sc);
        exp_src[r * TW + c] = s;
        dv = rom_word(s);
        x = int'(l) + c;
        y = int'(t) + r;
        if (x < SW && y < SH && !(ke && dv == KEYV))
          exp_q.push_back('{r * TW + c + 3, 19'(y * SW + x), dv});
      end
    end
    tile_id = tid;
    top = t;
    left = l;
    flip_h = fh;
    flip_v = fv;
    key_en = ke;
    @(negedge clk);
    start = 1'b1;
    for (int cyc = 1; cyc <= last_cyc; cyc++) begin
      @(negedge clk);
      start = b2b && (cyc == 5 || cyc == N + 3);
      scramble();
      if (cyc <= N) src_log[cyc-1] = src_addr;
      if (dst_wr) got_q.push_back('{cyc, dst_addr, dst_data});
      if (done) begin
        done_n++;
        done_at = cyc;
      end
      if (cyc == 1) b1 = busy;
      if (cyc == N + 2) bend = busy;
      if (cyc == N + 3) bdone = busy;
    end
    n_wr = got_q.size();
    s_first = src_log[0];
    s_last = src_log[N-1];

    bad = -1;
    for (int k = 0; k < N; k++)
      if (bad < 0 && src_log[k] !== exp_src[k]) bad = k;
    total_n++;
    if (bad >= 0)
      $display("FAIL %s src_seq idx %0d got %h want %h",
               nm, bad, src_log[bad], exp_src[bad]);
    else pass_n++;

    total_n++;
    if (got_q.size() !== exp_q.size())
      $display("FAIL %s wr_count got %0d want %0d",
               nm, got_q.size(), exp_q.size());
    else pass_n++;

    bad = -1;
    for (int k = 0; k < got_q.size() && k < exp_q.size(); k++)
      if (bad < 0 && (got_q[k].cyc != exp_q[k].cyc ||
          got_q[k].a !== exp_q[k].a || got_q[k].d !== exp_q[k].d))
        bad = k;
    total_n++;
    if (bad >= 0)
      $display("FAIL %s wr_item %0d got c%0d a%h d%h want c%0d a%h d%h",
               nm, bad, got_q[bad].cyc, got_q[bad].a, got_q[bad].d,
               exp_q[bad].cyc, exp_q[bad].a, exp_q[bad].d);
    else pass_n++;

    total_n++;
    if (done_n !== 1 || done_at !== N + 3)
      $display("FAIL %s done got n%0d at %0d want n1 at %0d",
               nm, done_n, done_at, N + 3);
    else pass_n++;

    total_n++;
    if ({b1, bend, bdone} !== 3'b110)
      $display("FAIL %s busy got %b want 110", nm, {b1, bend, bdone});
    else pass_n++;

    if (exp_q.size() > 0) begin
      total_n++;
      if (dst_addr !== exp_q[$].a || dst_data !== exp_q[$].d)
        $display("FAIL %s hold got %h/%h want %h/%h",
                 nm, dst_addr, dst_data, exp_q[$].a, exp_q[$].d);
      else pass_n++;
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    start = 1'b1;
    scramble();
    repeat (4) @(negedge clk);
    total_n++;
    if ({busy, done, dst_wr} !== 3'b000)
      $display("FAIL reset_flags got %b want 000", {busy, done, dst_wr});
    else pass_n++;
    total_n++;
    if (src_addr !== 19'd0 || dst_addr !== 19'd0 || dst_data !== 16'd0)
      $display("FAIL reset_regs got %h %h %h want 0 0 0",
               src_addr, dst_addr, dst_data);
    else pass_n++;
    start = 1'b0;
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int n;
    logic [18:0] f, l;
    run_render(19'd2, 10'd0, 10'd0, 0, 0, 0, 0, 0, "basic", n, f, l);
    total_n++;
    if (n !== 1024 || f !== 19'd2048)
      $display("FAIL basic_const got n%0d first %0d want n1024 first 2048",
               n, f);
    else pass_n++;
  endtask

  task automatic test_flip();
    int n;
    logic [18:0] f, l;
    run_render(19'd0, 10'd0, 10'd0, 1, 1, 0, 0, 0, "flip", n, f, l);
    total_n++;
    if (f !== 19'd1023 || l !== 19'd0)
      $display("FAIL flip_ends got %0d..%0d want 1023..0", f, l);
    else pass_n++;
  endtask

  task automatic test_clip();
    int n;
    logic [18:0] f, l;
    run_render(19'd2, 10'd470, 10'd620, 0, 0, 0, 0, 0, "clip", n, f, l);
    total_n++;
    if (n !== 200)
      $display("FAIL clip_count got %0d want 200", n);
    else pass_n++;
  endtask

  task automatic test_key();
    int n;
    logic [18:0] f, l;
    int even;
    run_render(19'd2, 10'd0, 10'd0, 0, 0, 1, 1, 0, "key", n, f, l);
    even = 0;
    foreach (got_q[k]) if (!got_q[k].d[0]) even++;
    total_n++;
    if (n !== 512 || even !== 0)
      $display("FAIL key_count got n%0d even %0d want n512 even 0",
               n, even);
    else pass_n++;
  endtask

  task automatic test_back_to_back();
    int n;
    logic [18:0] f, l;
    run_render(19'd3, 10'd100, 10'd200, 1, 0, 0, 0, 1, "b2b_a", n, f, l);
    run_render(19'd5, 10'd10, 10'd30, 0, 1, 1, 2, 0, "b2b_b", n, f, l);
    total_n++;
    if (f !== 19'd6112)
      $display("FAIL b2b_second_first got %0d want 6112", f);
    else pass_n++;
  endtask

  task automatic test_abort();
    int wr_n;
    int dn_n;
    rom_mode = 0;
    tile_id = 19'd1;
    top = 10'd0;
    left = 10'd0;
    flip_h = 1'b0;
    flip_v = 1'b0;
    key_en = 1'b0;
    @(negedge clk);
    start = 1'b1;
    for (int cyc = 1; cyc <= 300; cyc++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    total_n++;
    if ({busy, done, dst_wr} !== 3'b000 || src_addr !== 19'd0 ||
        dst_addr !== 19'd0 || dst_data !== 16'd0)
      $display("FAIL abort_state got %b %h %h %h want 000 0 0 0",
               {busy, done, dst_wr}, src_addr, dst_addr, dst_data);
    else pass_n++;
    wr_n = 0;
    dn_n = 0;
    repeat (N + 20) begin
      @(negedge clk);
      if (dst_wr) wr_n++;
      if (done) dn_n++;
    end
    total_n++;
    if (wr_n !== 0 || dn_n !== 0 || busy !== 1'b0)
      $display("FAIL abort_quiet got wr%0d done%0d busy%b want 0 0 0",
               wr_n, dn_n, busy);
    else pass_n++;
  endtask

  task automatic test_random();
    int n;
    logic [18:0] f, l;
    for (int i = 0; i < 4; i++) begin
      logic [9:0] t, lf;
      t = (i % 2 == 0) ? 10'($urandom_range(440, 1023))
                       : 10'($urandom_range(0, 479));
      lf = (i < 2) ? 10'($urandom_range(600, 1023))
                   : 10'($urandom_range(0, 639));
      run_render(19'($urandom_range(0, 40)), t, lf,
                 1'($urandom), 1'($urandom), 1'($urandom),
                 2, 0, $sformatf("rand%0d", i), n, f, l);
    end
  endtask

  initial begin
    rstn = 1'b0;
    start = 1'b0;
    tile_id = '0;
    top = '0;
    left = '0;
    flip_h = 1'b0;
    flip_v = 1'b0;
    key_en = 1'b0;
    test_reset();
    test_basic();
    test_flip();
    test_clip();
    test_key();
    test_back_to_back();
    test_abort();
    test_random();
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

endmodule
